gpioemu_host: RTL and testbench

Bus initiator that drives the gpioemu slave register interface (saddress/srd/swr/sdata) from a simple command/response handshake. One accepted command runs a complete multiply job: write both operands, trigger, poll status until done, read back the result and ones-count, and present them as one response. Sits between the test/host logic and the gpioemu peripheral, owning the peripheral's strobe timing.

---
 rtl/gpioemu_host.sv | 195 +++++++++++++++++++
 tb/tb_gpioemu_host.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_host.sv
`default_nettype none
// ============================================================================
//  Module   : gpioemu_host
//  Purpose  : Bus initiator for the gpioemu slave register interface. One
//             accepted command runs a full multiply job: write A1 and A2,
//             write GO, poll STATUS until done (or give up), read W twice
//             and COUNT once, then present everything as one response.
//  Ports    : clk, n_reset (async, active-low)
//             cmd_valid/cmd_ready/cmd_a1/cmd_a2      - job request handshake
//             res_valid/res_ready/res_w/res_count/
//             res_status/res_timeout                 - job response handshake
//             saddress/srd/swr/sdata_out/sdata_in    - peripheral bus
//  Revision : 1.0 - initial release
// ============================================================================
module gpioemu_host #(
   parameter int         STROBE_CYCLES = 2,
   parameter int         POLL_GAP      = 4,
   parameter int         POLL_MAX      = 255,
   parameter logic [1:0] DONE_VALUE    = 2'b11
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_a1,
   input  logic [23:0] cmd_a2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_w,
   output logic [23:0] res_count,
   output logic [1:0]  res_status,
   output logic        res_timeout,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_out,
   input  logic [31:0] sdata_in
);

   localparam logic [15:0] ADDR_A1  = 16'h037F;
   localparam logic [15:0] ADDR_A2  = 16'h0388;
   localparam logic [15:0] ADDR_GO  = 16'h03A0;
   localparam logic [15:0] ADDR_W   = 16'h0390;
   localparam logic [15:0] ADDR_CNT = 16'h0398;

   // step: 0 = SETUP, 1..STROBE_CYCLES = STROBE, STROBE_CYCLES+1 = HOLD
   localparam int          SW         = $clog2(STROBE_CYCLES + 2) + 1;
   localparam logic [SW-1:0] STB_LAST  = SW'(STROBE_CYCLES);
   localparam int          GW         = $clog2(POLL_GAP + 2) + 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
   localparam logic [8:0]  POLL_LIMIT = 9'(POLL_MAX);

   typedef enum logic [3:0] {
      IDLE, WR_A1, WR_A2, WR_GO, POLL, POLL_WAIT, RD_W0, RD_W1, RD_CNT, RESP
   } state_t;

   state_t        state;
   logic [SW-1:0] step;
   logic [GW-1:0] gap;
   logic [7:0]    poll_cnt;
   logic [23:0]   a2_q;
   logic          is_write;
   logic [8:0]    poll_next;

   always_comb begin
      is_write  = (state == WR_A1) || (state == WR_A2) || (state == WR_GO);
      poll_next = {1'b0, poll_cnt} + 9'd1;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= IDLE;
         step        <= '0;
         gap         <= '0;
         poll_cnt    <= 8'd0;
         a2_q        <= 24'd0;
         cmd_ready   <= 1'b1;
         res_valid   <= 1'b0;
         res_w       <= 32'd0;
         res_count   <= 24'd0;
         res_status  <= 2'd0;
         res_timeout <= 1'b0;
         saddress    <= 16'd0;
         srd         <= 1'b0;
         swr         <= 1'b0;
         sdata_out   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  // Results are cleared here so a timeout response carries zeros.
                  a2_q        <= cmd_a2;
                  poll_cnt    <= 8'd0;
                  cmd_ready   <= 1'b0;
                  res_w       <= 32'd0;
                  res_count   <= 24'd0;
                  res_status  <= 2'd0;
                  res_timeout <= 1'b0;
                  step        <= '0;
                  state       <= WR_A1;
                  saddress    <= ADDR_A1;
                  sdata_out   <= {8'h00, cmd_a1};
               end
            end

            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            POLL_WAIT: begin
               // Address is still STATUS from the previous poll.
               if (gap == GAP_LAST) begin
                  state <= POLL;
               end else begin
                  gap <= gap + 1'b1;
               end
            end

            default: begin
               if (step == '0) begin
                  swr  <= is_write;
                  srd  <= !is_write;
                  step <= step + 1'b1;
               end else if (step < STB_LAST) begin
                  step <= step + 1'b1;
               end else if (step == STB_LAST) begin
                  swr  <= 1'b0;
                  srd  <= 1'b0;
                  step <= step + 1'b1;
                  case (state)
                     POLL:    res_status <= sdata_in[1:0];
                     RD_W1:   res_w      <= sdata_in;
                     RD_CNT:  res_count  <= sdata_in[23:0];
                     default: ;
                  endcase
               end else begin
                  // HOLD: next access starts with its SETUP on the following cycle.
                  step <= '0;
                  case (state)
                     WR_A1: begin
                        state     <= WR_A2;
                        saddress  <= ADDR_A2;
                        sdata_out <= {8'h00, a2_q};
                     end
                     WR_A2: begin
                        state     <= WR_GO;
                        saddress  <= ADDR_GO;
                        sdata_out <= 32'd0;
                     end
                     WR_GO: begin
                        state <= POLL;
                     end
                     POLL: begin
                        if (res_status == DONE_VALUE) begin
                           state    <= RD_W0;
                           saddress <= ADDR_W;
                        end else if (poll_next == POLL_LIMIT) begin
                           poll_cnt    <= poll_next[7:0];
                           res_timeout <= 1'b1;
                           res_valid   <= 1'b1;
                           state       <= RESP;
                        end else begin
                           poll_cnt <= poll_next[7:0];
                           gap      <= '0;
                           state    <= (POLL_GAP == 0) ? POLL : POLL_WAIT;
                        end
                     end
                     // W only updates on a read strobe, so the first read is stale.
                     RD_W0: begin
                        state <= RD_W1;
                     end
                     RD_W1: begin
                        state    <= RD_CNT;
                        saddress <= ADDR_CNT;
                     end
                     RD_CNT: begin
                        res_valid <= 1'b1;
                        state     <= RESP;
                     end
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpioemu_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpioemu_host
//  Purpose  : Self-checking bench for gpioemu_host. Three instances with
//             STROBE_CYCLES = 2, 1, 5, each with a small peripheral model
//             and a per-cycle monitor that compares bus trace, strobe shape,
//             handshake timing and response values against a job model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpioemu_host;

   localparam int POLL_GAP = 4;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [2:0]  cmd_valid;
   logic [2:0]  res_ready;
   logic [2:0]  res_valid_v;
   logic [2:0]  cmd_ready_v;
   logic [23:0] cmd_a1;
   logic [23:0] cmd_a2;

   // per-instance job description used by the peripheral model and monitor
   logic [23:0] a1v [3];
   logic [23:0] a2v [3];
   logic [31:0] wv  [3];
   logic [23:0] cv  [3];
   logic [1:0]  scr [3][3];
   int          scr_n [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // status returned by the i-th STATUS read of a job (last entry repeats)
   function automatic logic [1:0] stat_at(input int g, input int i);
      int k;
      if (scr_n[g] <= 0) return 2'd0;
      k = (i < 0) ? 0 : i;
      if (k > scr_n[g] - 1) k = scr_n[g] - 1;
      return scr[g][k];
   endfunction

   // k-th bus access of a job with n polls
   function automatic void exp_acc(input int k, input int n, input bit dn,
                                   input logic [23:0] x1, input logic [23:0] x2,
                                   output bit v, output logic w,
                                   output logic [15:0] a, output logic [31:0] d);
      v = 1'b1; w = 1'b0; a = 16'hFFFF; d = 32'd0;
      if (k == 0)                begin w = 1'b1; a = 16'h037F; d = {8'h00, x1}; end
      else if (k == 1)           begin w = 1'b1; a = 16'h0388; d = {8'h00, x2}; end
      else if (k == 2)           begin w = 1'b1; a = 16'h03A0; end
      else if (k < 3 + n)        a = 16'h03A0;
      else if (dn && k < 5 + n)  a = 16'h0390;
      else if (dn && k == 5 + n) a = 16'h0398;
      else                       v = 1'b0;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      logic [15:0] saddress;
      logic        srd, swr, res_valid, cmd_ready, res_timeout;
      logic [31:0] sdata_out, sdata_in, res_w;
      logic [23:0] res_count;
      logic [1:0]  res_status;

      int  st_cnt, w_cnt, acc, cyc, wid, n_polls, lat_exp, last_fall;
      bit  busy, done;
      logic p_rd, p_wr;
      logic [15:0] p_addr;
      logic [31:0] p_data;

      gpioemu_host #(
         .STROBE_CYCLES(S), .POLL_GAP(POLL_GAP), .POLL_MAX(255), .DONE_VALUE(2'b11)
      ) u_dut (
         .clk(clk), .n_reset(n_reset),
         .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready),
         .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
         .res_valid(res_valid), .res_ready(res_ready[g]),
         .res_w(res_w), .res_count(res_count), .res_status(res_status),
         .res_timeout(res_timeout),
         .saddress(saddress), .srd(srd), .swr(swr),
         .sdata_out(sdata_out), .sdata_in(sdata_in)
      );

      assign res_valid_v[g] = res_valid;
      assign cmd_ready_v[g] = cmd_ready;

      // peripheral: upper bits carry junk so field masking is exercised
      always_comb begin
         sdata_in = 32'd0;
         if (saddress == 16'h03A0)      sdata_in = 32'hABCD_EF00 | {30'd0, stat_at(g, st_cnt - 1)};
         else if (saddress == 16'h0390) sdata_in = (w_cnt >= 2) ? wv[g] : 32'hDEAD_BEEF;
         else if (saddress == 16'h0398) sdata_in = {8'hFF, cv[g]};
      end

      always @(negedge clk) begin : p_mon
         bit          ev;
         logic        ew;
         logic [15:0] ea;
         logic [31:0] ed;
         if (!n_reset) begin
            busy = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = 16'd0; p_data = 32'd0;
         end else begin
            chk_eq("both_strobes", 32'(srd & swr), 32'd0);
            if ((srd | swr) && !(p_rd | p_wr)) begin
               chk_eq("setup_addr", 32'(saddress), 32'(p_addr));
               chk_eq("setup_data", sdata_out, p_data);
               exp_acc(acc, n_polls, done, a1v[g], a2v[g], ev, ew, ea, ed);
               chk_eq("acc_expected", 32'(ev), 32'd1);
               chk_eq("acc_kind", 32'(swr), 32'(ew));
               chk_eq("acc_addr", 32'(saddress), 32'(ea));
               if (ew) chk_eq("acc_data", sdata_out, ed);
               if (srd && saddress == 16'h03A0) begin
                  if (st_cnt > 0) chk_eq("poll_gap", cyc - last_fall, POLL_GAP + 2);
                  st_cnt++;
               end
               if (srd && saddress == 16'h0390) w_cnt++;
               acc++;
               wid = 1;
            end else if (srd | swr) begin
               chk_eq("strobe_addr", 32'(saddress), 32'(p_addr));
               chk_eq("strobe_data", sdata_out, p_data);
               wid++;
            end else if (p_rd | p_wr) begin
               chk_eq("strobe_width", wid, S);
               chk_eq("hold_addr", 32'(saddress), 32'(p_addr));
               chk_eq("hold_data", sdata_out, p_data);
               if (p_rd && saddress == 16'h03A0) last_fall = cyc;
            end

            if (busy) begin
               cyc++;
               chk_eq("res_valid", 32'(res_valid), 32'(cyc >= lat_exp));
               chk_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
               if (cyc >= lat_exp) begin
                  chk_eq("res_w", res_w, done ? wv[g] : 32'd0);
                  chk_eq("res_count", 32'(res_count), done ? 32'(cv[g]) : 32'd0);
                  chk_eq("res_status", 32'(res_status), done ? 32'd3 : 32'(stat_at(g, 254)));
                  chk_eq("res_timeout", 32'(res_timeout), 32'(!done));
               end
               if (res_valid && res_ready[g]) busy = 1'b0;
            end else begin
               chk_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
               chk_eq("res_valid_idle", 32'(res_valid), 32'd0);
               if (cmd_valid[g]) begin
                  busy = 1'b1; cyc = 0; acc = 0; st_cnt = 0; w_cnt = 0;
                  done = 1'b0; n_polls = 255;
                  for (int i = 0; i < 255; i++) begin
                     if (!done && stat_at(g, i) == 2'b11) begin
                        done = 1'b1; n_polls = i + 1;
                     end
                  end
                  lat_exp = (S + 2) * ((done ? 6 : 3) + n_polls) + POLL_GAP * (n_polls - 1) + 1;
               end
            end
            p_rd = srd; p_wr = swr; p_addr = saddress; p_data = sdata_out;
         end
      end
   end

   task automatic set_job(input int g, input logic [23:0] x1, input logic [23:0] x2, input int n,
                          input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] w, input logic [23:0] c);
      a1v[g] = x1; a2v[g] = x2; wv[g] = w; cv[g] = c;
      scr[g][0] = s0; scr[g][1] = s1; scr[g][2] = s2; scr_n[g] = n;
      cmd_a1 = x1; cmd_a2 = x2;
   endtask

   // issue a command and wait for res_valid; lat = cycles from accept
   task automatic run_job(input int g, input int bp, output int lat);
      @(posedge clk); #1; cmd_valid[g] = 1'b1;
      @(posedge clk); #1; cmd_valid[g] = 1'b0;
      lat = 1;
      while (!res_valid_v[g] && lat < 4000) begin
         @(posedge clk); #1; lat++;
      end
      chk_eq("job_finished", 32'(res_valid_v[g]), 32'd1);
      if (bp > 0) begin
         cmd_valid[g] = 1'b1;
         repeat (bp) begin @(posedge clk); #1; end
         cmd_valid[g] = 1'b0;
         chk_eq("bp_cmd_ready", 32'(cmd_ready_v[g]), 32'd0);
         chk_eq("bp_res_valid", 32'(res_valid_v[g]), 32'd1);
      end
   endtask

   task automatic ack(input int g);
      res_ready[g] = 1'b1;
      @(posedge clk); #1;
      res_ready[g] = 1'b0;
      chk_eq("ack_res_valid", 32'(res_valid_v[g]), 32'd0);
      chk_eq("ack_cmd_ready", 32'(cmd_ready_v[g]), 32'd1);
   endtask

   initial begin
      int lat;
      int k;
      n_reset = 1'b0; cmd_valid = 3'b000; res_ready = 3'b000; cmd_a1 = 24'd0; cmd_a2 = 24'd0;
      for (int i = 0; i < 3; i++) set_job(i, 24'd0, 24'd0, 1, 2'd3, 2'd3, 2'd3, 32'd0, 24'd0);
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_saddress", 32'(g_inst[0].saddress), 32'd0);
      chk_eq("rst_srd", 32'(g_inst[0].srd), 32'd0);
      chk_eq("rst_swr", 32'(g_inst[0].swr), 32'd0);
      chk_eq("rst_sdata_out", g_inst[0].sdata_out, 32'd0);
      chk_eq("rst_cmd_ready", 32'(g_inst[0].cmd_ready), 32'd1);
      chk_eq("rst_res_valid", 32'(g_inst[0].res_valid), 32'd0);
      chk_eq("rst_res_w", g_inst[0].res_w, 32'd0);
      chk_eq("rst_res_count", 32'(g_inst[0].res_count), 32'd0);
      chk_eq("rst_res_status", 32'(g_inst[0].res_status), 32'd0);
      chk_eq("rst_res_timeout", 32'(g_inst[0].res_timeout), 32'd0);
      n_reset = 1'b1;

      // res_ready while idle must do nothing
      res_ready[0] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      res_ready[0] = 1'b0;

      // basic job
      set_job(0, 24'd5, 24'd3, 1, 2'd3, 2'd3, 2'd3, 32'd40, 24'd1);
      run_job(0, 0, lat);
      chk_eq("basic_latency", lat, 29);
      chk_eq("basic_res_w", g_inst[0].res_w, 32'd40);
      chk_eq("basic_res_count", 32'(g_inst[0].res_count), 32'd1);
      chk_eq("basic_res_timeout", 32'(g_inst[0].res_timeout), 32'd0);
      chk_eq("basic_status_reads", g_inst[0].st_cnt, 1);
      ack(0);

      // polling: status 0,0,3
      set_job(0, 24'hFFFFFF, 24'h000017, 3, 2'd0, 2'd0, 2'd3, 32'h1234_5678, 24'h0ABCDE);
      run_job(0, 0, lat);
      chk_eq("poll_latency", lat, 45);
      chk_eq("poll_status_reads", g_inst[0].st_cnt, 3);
      chk_eq("poll_res_w", g_inst[0].res_w, 32'h1234_5678);
      chk_eq("poll_res_count", 32'(g_inst[0].res_count), 32'h0ABCDE);
      ack(0);

      // back-pressure with non-done status values 1 and 2
      set_job(0, 24'h00C0DE, 24'h000001, 3, 2'd1, 2'd2, 2'd3, 32'hCAFE_F00D, 24'h00FACE);
      run_job(0, 10, lat);
      chk_eq("bp_res_w", g_inst[0].res_w, 32'hCAFE_F00D);
      chk_eq("bp_res_status", 32'(g_inst[0].res_status), 32'd3);
      ack(0);

      // timeout: status stuck at 0
      set_job(0, 24'd11, 24'd2, 1, 2'd0, 2'd0, 2'd0, 32'h5555_AAAA, 24'h123456);
      run_job(0, 0, lat);
      chk_eq("to_latency", lat, 2049);
      chk_eq("to_status_reads", g_inst[0].st_cnt, 255);
      chk_eq("to_w_reads", g_inst[0].w_cnt, 0);
      chk_eq("to_res_timeout", 32'(g_inst[0].res_timeout), 32'd1);
      chk_eq("to_res_w", g_inst[0].res_w, 32'd0);
      chk_eq("to_res_count", 32'(g_inst[0].res_count), 32'd0);
      ack(0);

      // asynchronous reset in the middle of the WR_A2 strobe
      set_job(0, 24'd7, 24'd9, 1, 2'd3, 2'd3, 2'd3, 32'd99, 24'd2);
      @(posedge clk); #1; cmd_valid[0] = 1'b1;
      @(posedge clk); #1; cmd_valid[0] = 1'b0;
      k = 0;
      while (!(g_inst[0].swr && g_inst[0].saddress == 16'h0388) && k < 100) begin
         @(negedge clk); k++;
      end
      chk_eq("reach_wr_a2", 32'(g_inst[0].swr), 32'd1);
      #2; n_reset = 1'b0; #1;
      chk_eq("arst_swr", 32'(g_inst[0].swr), 32'd0);
      chk_eq("arst_srd", 32'(g_inst[0].srd), 32'd0);
      chk_eq("arst_saddress", 32'(g_inst[0].saddress), 32'd0);
      chk_eq("arst_cmd_ready", 32'(g_inst[0].cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1; n_reset = 1'b1;
      run_job(0, 0, lat);
      chk_eq("restart_latency", lat, 29);
      chk_eq("restart_res_w", g_inst[0].res_w, 32'd99);
      ack(0);

      // strobe width 1
      set_job(1, 24'h000042, 24'd4, 1, 2'd3, 2'd3, 2'd3, 32'h0000_0420, 24'd2);
      run_job(1, 0, lat);
      chk_eq("s1_latency", lat, 22);
      ack(1);

      // strobe width 5, two polls
      set_job(2, 24'h800001, 24'd23, 2, 2'd0, 2'd3, 2'd3, 32'hFEDC_BA98, 24'h00FFFF);
      run_job(2, 0, lat);
      chk_eq("s5_latency", lat, 61);
      ack(2);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
